// File: rtl/alu_seq_pkg.sv
// -----------------------------------------------------------------------------
// alu_seq_pkg
// Shared definitions for the 8-bit ALU (alu) and its byte-serial sequencer
// (alu_seq): opcode encoding, the carry convention and opcode classification
// helpers.
//
// Carry convention: for ADD, cout is the carry out of bit 7. For SUB, cout is
// the borrow, meaning it is 1 when a < b (unsigned). For the logic ops, cout
// is always 0.
// -----------------------------------------------------------------------------
package alu_seq_pkg;

    localparam logic [3:0] ALU_ADD = 4'h0;
    localparam logic [3:0] ALU_SUB = 4'h1;
    localparam logic [3:0] ALU_AND = 4'h2;
    localparam logic [3:0] ALU_OR  = 4'h3;
    localparam logic [3:0] ALU_XOR = 4'h4;

    // True for the ops that propagate a carry/borrow between bytes.
    function automatic logic op_is_arith(input logic [3:0] op);
        return (op == ALU_ADD) || (op == ALU_SUB);
    endfunction

    // Every code outside ADD..XOR is rejected with rsp_err.
    function automatic logic op_supported(input logic [3:0] op);
        return (op == ALU_ADD) || (op == ALU_SUB) || (op == ALU_AND) ||
               (op == ALU_OR)  || (op == ALU_XOR);
    endfunction

endpackage

// File: rtl/alu.sv
// -----------------------------------------------------------------------------
// alu
// Shared combinational 8-bit ALU.
//
// Ports:
//   a_i, b_i  in   8  operands
//   op_i      in   4  opcode (alu_seq_pkg encoding)
//   y_o       out  8  result
//   cout_o    out  1  ADD carry / SUB borrow, 0 for logic ops
//
// Unsupported opcodes produce y_o = 0 and cout_o = 0.
// -----------------------------------------------------------------------------
module alu
    import alu_seq_pkg::*;
(
    input  logic [7:0] a_i,
    input  logic [7:0] b_i,
    input  logic [3:0] op_i,
    output logic [7:0] y_o,
    output logic       cout_o
);

    always_comb begin
        y_o    = 8'h00;
        cout_o = 1'b0;
        case (op_i)
            // The 9-bit sum places the carry in bit 8.
            ALU_ADD: {cout_o, y_o} = {1'b0, a_i} + {1'b0, b_i};
            // Bit 8 of the 9-bit difference is set exactly when a < b,
            // so it gives the borrow.
            ALU_SUB: {cout_o, y_o} = {1'b0, a_i} - {1'b0, b_i};
            ALU_AND: y_o = a_i & b_i;
            ALU_OR:  y_o = a_i | b_i;
            ALU_XOR: y_o = a_i ^ b_i;
            default: begin
                y_o    = 8'h00;
                cout_o = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/alu_seq.sv
// -----------------------------------------------------------------------------
// alu_seq
// Executes W-bit (W = 8*NBYTES) ADD/SUB/AND/OR/XOR by driving a shared external
// 8-bit ALU one byte at a time, starting with the least-significant byte.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   req_valid/req_ready   command handshake; req_op, req_a, req_b carry the command
//   rsp_valid/rsp_ready   response handshake; rsp_data, rsp_cout, rsp_err carry the result
//   alu_a, alu_b, alu_op  drive the shared ALU (zero when not in PASS/FIX)
//   alu_out, alu_cout     combinational ALU result for the current drive
//
// Carry handling: the ALU has no carry input. After a byte's PASS, a pending
// carry/borrow into that byte is applied by a FIX cycle. In that cycle the byte
// goes through the ALU again with operand 1. A byte can produce a carry-out in
// PASS or in FIX, but never in both, so OR-ing the two gives the carry-out.
// -----------------------------------------------------------------------------
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter  int NBYTES = 2,
    localparam int W      = 8 * NBYTES
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic [3:0]   req_op,
    input  logic [W-1:0] req_a,
    input  logic [W-1:0] req_b,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [W-1:0] rsp_data,
    output logic         rsp_cout,
    output logic         rsp_err,
    output logic [7:0]   alu_a,
    output logic [7:0]   alu_b,
    output logic [3:0]   alu_op,
    input  logic [7:0]   alu_out,
    input  logic         alu_cout
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PASS = 2'd1,
        S_FIX  = 2'd2,
        S_RESP = 2'd3
    } state_t;

    localparam logic [1:0] LAST_BYTE = 2'(NBYTES - 1);

    state_t       state_q;
    logic [1:0]   cnt_q;
    logic         cin_q;
    logic         c1_q;
    logic [3:0]   op_q;
    logic [W-1:0] a_q;
    logic [W-1:0] b_q;
    logic [W-1:0] res_q;
    logic         req_ready_q;
    logic         rsp_valid_q;
    logic [W-1:0] rsp_data_q;
    logic         rsp_cout_q;
    logic         rsp_err_q;

    logic [W-1:0] res_d;
    logic         c1_d;
    logic         carry_out_d;

    // ALU drive is decoded from the registered state, so the ALU result is
    // valid during the same PASS/FIX cycle.
    always_comb begin
        alu_a  = 8'h00;
        alu_b  = 8'h00;
        alu_op = 4'h0;
        case (state_q)
            S_PASS: begin
                alu_a  = a_q[cnt_q*8 +: 8];
                alu_b  = b_q[cnt_q*8 +: 8];
                alu_op = op_q;
            end
            S_FIX: begin
                alu_a  = res_q[cnt_q*8 +: 8];
                alu_b  = 8'h01;
                alu_op = op_q;
            end
            default: ;
        endcase
    end

    // Result with the current byte replaced by the ALU output, plus the
    // carry-out this cycle would hand to the next byte.
    always_comb begin
        res_d                = res_q;
        res_d[cnt_q*8 +: 8]  = alu_out;
        c1_d                 = op_is_arith(op_q) ? alu_cout : 1'b0;
        carry_out_d          = (state_q == S_FIX) ? (c1_q | alu_cout) : c1_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_cout_q  <= 1'b0;
            rsp_err_q   <= 1'b0;
            cnt_q       <= 2'd0;
            cin_q       <= 1'b0;
            c1_q        <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req_valid && req_ready_q) begin
                        op_q        <= req_op;
                        a_q         <= req_a;
                        b_q         <= req_b;
                        cnt_q       <= 2'd0;
                        cin_q       <= 1'b0;
                        c1_q        <= 1'b0;
                        req_ready_q <= 1'b0;
                        if (op_supported(req_op)) begin
                            state_q <= S_PASS;
                        end else begin
                            state_q     <= S_RESP;
                            rsp_valid_q <= 1'b1;
                            rsp_data_q  <= '0;
                            rsp_cout_q  <= 1'b0;
                            rsp_err_q   <= 1'b1;
                        end
                    end
                end

                S_PASS, S_FIX: begin
                    res_q <= res_d;
                    if (state_q == S_PASS) begin
                        c1_q <= c1_d;
                    end
                    if (state_q == S_PASS && op_is_arith(op_q) && cin_q) begin
                        state_q <= S_FIX;
                    end else if (cnt_q == LAST_BYTE) begin
                        state_q     <= S_RESP;
                        rsp_valid_q <= 1'b1;
                        rsp_data_q  <= res_d;
                        rsp_cout_q  <= carry_out_d;
                        rsp_err_q   <= 1'b0;
                    end else begin
                        cnt_q   <= cnt_q + 2'd1;
                        cin_q   <= carry_out_d;
                        state_q <= S_PASS;
                    end
                end

                S_RESP: begin
                    if (rsp_ready) begin
                        state_q     <= S_IDLE;
                        rsp_valid_q <= 1'b0;
                        req_ready_q <= 1'b1;
                    end
                end

                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_cout  = rsp_cout_q;
    assign rsp_err   = rsp_err_q;

endmodule
